// File: rtl/pulse_extend_arb.sv
// pulse_extend_arb
//
// Shares one stretched-pulse output channel between REQ_NUM requesters.
// Each requester fires single-cycle valid/data pulses. Every pulse is held
// as pending until a round-robin arbiter grants it. The granted request
// then owns o_vld/o_vld_data for EXTEND_CYC_NUM cycles, followed by
// GAP_CYC_NUM forced-idle guard cycles before the next grant.
//
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous, active-low reset
//   i_req_vld   per-requester request pulse
//   i_req_data  per-requester data bit, sampled with its i_req_vld
//   i_flush     synchronous abort of the current grant and all pending requests
//   o_vld       extended valid
//   o_vld_data  extended data, 0 whenever o_vld is 0
//   o_gnt_id    requester being served; holds its last value when idle
//   o_done      one-hot pulse on the final o_vld cycle of a grant
//   o_drop      pulse when a pending request was overwritten before service
//   o_busy      high whenever the arbiter is not idle
module pulse_extend_arb #(
    parameter  int REQ_NUM        = 4,
    parameter  int EXTEND_CYC_NUM = 12,
    parameter  int GAP_CYC_NUM    = 2,
    localparam int IDW            = (REQ_NUM == 1) ? 1 : $clog2(REQ_NUM),
    localparam int MAX_CYC        = (EXTEND_CYC_NUM > GAP_CYC_NUM) ? EXTEND_CYC_NUM : GAP_CYC_NUM,
    localparam int CNT_W          = $clog2(MAX_CYC + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [REQ_NUM-1:0] i_req_vld,
    input  logic [REQ_NUM-1:0] i_req_data,
    input  logic               i_flush,
    output logic               o_vld,
    output logic               o_vld_data,
    output logic [IDW-1:0]     o_gnt_id,
    output logic [REQ_NUM-1:0] o_done,
    output logic [REQ_NUM-1:0] o_drop,
    output logic               o_busy
);

    localparam int EXT_LAST = EXTEND_CYC_NUM - 1;
    // GAP is never entered when GAP_CYC_NUM is 0, so the clamp only keeps the constant legal.
    localparam int GAP_LAST = (GAP_CYC_NUM > 0) ? GAP_CYC_NUM - 1 : 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXTEND = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]     rrPtr_q, rrPtr_d;
    logic [IDW-1:0]     gntId_d;
    logic               data_q, data_d;
    logic [REQ_NUM-1:0] pend_q, pend_d;
    logic [REQ_NUM-1:0] pendData_q, pendData_d;
    logic [REQ_NUM-1:0] drop_d;
    logic [REQ_NUM-1:0] done_d;
    logic               lastExt, lastGap, arbSlot, grantNow;
    logic               winFound;
    logic [IDW-1:0]     winId, candId;

    // Round-robin search: first pending requester strictly after rrPtr_q, wrapping.
    always_comb begin
        winFound = 1'b0;
        winId    = rrPtr_q;
        candId   = '0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            candId = IDW'((int'(rrPtr_q) + i) % REQ_NUM);
            if (!winFound && pend_q[candId]) begin
                winFound = 1'b1;
                winId    = candId;
            end
        end
    end

    // Arbitration is allowed when idle, on the last GAP cycle, or on the last
    // EXTEND cycle when there is no guard gap at all.
    always_comb begin
        lastExt  = (state_q == EXTEND) && (cnt_q == CNT_W'(EXT_LAST));
        lastGap  = (state_q == GAP) && (cnt_q == CNT_W'(GAP_LAST));
        arbSlot  = (state_q == IDLE) || lastGap || (lastExt && (GAP_CYC_NUM == 0));
        grantNow = arbSlot && winFound;
    end

    // Next-state logic for the pending latches, counter and grant.
    // A fresh pulse on the requester being granted re-arms its pending bit
    // with new data; the grant itself takes the data captured earlier.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rrPtr_d    = rrPtr_q;
        gntId_d    = o_gnt_id;
        data_d     = data_q;
        pend_d     = pend_q;
        pendData_d = pendData_q;
        drop_d     = '0;
        done_d     = '0;

        if (grantNow) begin
            pend_d[winId] = 1'b0;
        end

        for (int k = 0; k < REQ_NUM; k++) begin
            if (i_req_vld[k]) begin
                if (pend_q[k] && !(grantNow && (winId == IDW'(k)))) begin
                    drop_d[k] = 1'b1;
                end
                pend_d[k]     = 1'b1;
                pendData_d[k] = i_req_data[k];
            end
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
            end
            EXTEND: begin
                if (lastExt) begin
                    state_d = (GAP_CYC_NUM > 0) ? GAP : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (lastGap) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (grantNow) begin
            state_d = EXTEND;
            cnt_d   = '0;
            rrPtr_d = winId;
            gntId_d = winId;
            data_d  = pendData_q[winId];
        end

        // Flush wins over everything, including requests arriving in the same cycle.
        if (i_flush) begin
            state_d    = IDLE;
            cnt_d      = '0;
            rrPtr_d    = rrPtr_q;
            gntId_d    = o_gnt_id;
            data_d     = data_q;
            pend_d     = '0;
            pendData_d = '0;
            drop_d     = '0;
        end

        if ((state_d == EXTEND) && (cnt_d == CNT_W'(EXT_LAST))) begin
            done_d = REQ_NUM'(1) << gntId_d;
        end
    end

    // State register; outputs are registered from the next-state values so
    // they line up exactly with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rrPtr_q    <= IDW'(REQ_NUM - 1);
            data_q     <= 1'b0;
            pend_q     <= '0;
            pendData_q <= '0;
            o_vld      <= 1'b0;
            o_vld_data <= 1'b0;
            o_gnt_id   <= '0;
            o_done     <= '0;
            o_drop     <= '0;
            o_busy     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rrPtr_q    <= rrPtr_d;
            data_q     <= data_d;
            pend_q     <= pend_d;
            pendData_q <= pendData_d;
            o_vld      <= (state_d == EXTEND);
            o_vld_data <= (state_d == EXTEND) && data_d;
            o_gnt_id   <= gntId_d;
            o_done     <= done_d;
            o_drop     <= drop_d;
            o_busy     <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_pulse_extend_arb.sv
// tb_pulse_extend_arb
//
// Directed bench for pulse_extend_arb. The main instance uses REQ_NUM=4,
// EXTEND_CYC_NUM=3, GAP_CYC_NUM=1; a second instance covers the
// REQ_NUM=1, EXTEND_CYC_NUM=1, GAP_CYC_NUM=0 back-to-back corner.
// Expected per-cycle output words are queued when a test's stimulus is
// planned and popped one per cycle as the DUT produces output.
module tb_pulse_extend_arb;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [3:0] reqVld;
    logic [3:0] reqData;
    logic       flush;
    logic       vld;
    logic       vldData;
    logic [1:0] gntId;
    logic [3:0] done;
    logic [3:0] drop;
    logic       busy;

    logic [0:0] cReqVld;
    logic [0:0] cReqData;
    logic       cFlush;
    logic       cVld;
    logic       cVldData;
    logic [0:0] cGntId;
    logic [0:0] cDone;
    logic [0:0] cDrop;
    logic       cBusy;

    int checks = 0;
    int errors = 0;
    int cyc    = -1;

    // Word layout: {vld, data, id[1:0], done[3:0], drop[3:0], busy}
    logic [12:0] frame [0:31];
    logic [12:0] expQ [$];
    // Corner word layout: {vld, data, id, done, drop, busy}
    logic [5:0]  cornerQ [$];

    always #5 i_clk = ~i_clk;

    pulse_extend_arb #(
        .REQ_NUM(4),
        .EXTEND_CYC_NUM(3),
        .GAP_CYC_NUM(1)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_req_vld(reqVld),
        .i_req_data(reqData),
        .i_flush(flush),
        .o_vld(vld),
        .o_vld_data(vldData),
        .o_gnt_id(gntId),
        .o_done(done),
        .o_drop(drop),
        .o_busy(busy)
    );

    pulse_extend_arb #(
        .REQ_NUM(1),
        .EXTEND_CYC_NUM(1),
        .GAP_CYC_NUM(0)
    ) dutCorner (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_req_vld(cReqVld),
        .i_req_data(cReqData),
        .i_flush(cFlush),
        .o_vld(cVld),
        .o_vld_data(cVldData),
        .o_gnt_id(cGntId),
        .o_done(cDone),
        .o_drop(cDrop),
        .o_busy(cBusy)
    );

    // Idle cycles: nothing driven, id holds, not busy.
    task automatic setIdle(input int a, input int b, input logic [1:0] id);
        for (int c = a; c <= b; c++) begin
            frame[c] = {1'b0, 1'b0, id, 4'b0000, 4'b0000, 1'b0};
        end
    endtask

    // Three EXTEND cycles with done on the last, then one GAP cycle.
    task automatic setGrant(input int s, input logic [1:0] id, input logic d);
        for (int c = s; c < s + 3; c++) begin
            frame[c] = {1'b1, d, id, (c == s + 2) ? (4'b0001 << id) : 4'b0000, 4'b0000, 1'b1};
        end
        frame[s + 3] = {1'b0, 1'b0, id, 4'b0000, 4'b0000, 1'b1};
    endtask

    task automatic enqueue(input int n);
        for (int c = 0; c < n; c++) begin
            expQ.push_back(frame[c]);
        end
    endtask

    task automatic resetDut();
        @(negedge i_clk);
        i_rst_n  = 1'b0;
        reqVld   = '0;
        reqData  = '0;
        flush    = 1'b0;
        cReqVld  = '0;
        cReqData = '0;
        cFlush   = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cyc     = -1;
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] d, input logic f,
                                 input logic cv = 1'b0, input logic cd = 1'b0);
        @(posedge i_clk);
        cyc++;
        #1;
        reqVld      = v;
        reqData     = d;
        flush       = f;
        cReqVld[0]  = cv;
        cReqData[0] = cd;
    endtask

    task automatic checkOutput(input string tag);
        logic [12:0] obs;
        logic [12:0] exp;
        logic [5:0]  cObs;
        logic [5:0]  cExp;
        @(negedge i_clk);
        obs = {vld, vldData, gntId, done, drop, busy};
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $error("FAIL %s cyc=%0d scoreboard empty, observed=%h", tag, cyc, obs);
        end else begin
            exp = expQ.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
            end
        end
        if (cornerQ.size() > 0) begin
            cObs = {cVld, cVldData, cGntId, cDone, cDrop, cBusy};
            cExp = cornerQ.pop_front();
            checks++;
            assert (cObs === cExp) else begin
                errors++;
                $error("FAIL %s_corner cyc=%0d observed=%b expected=%b", tag, cyc, cObs, cExp);
            end
        end
    endtask

    task automatic checkDrained(input string tag);
        checks++;
        assert (expQ.size() == 0) else begin
            errors++;
            $error("FAIL %s drained observed=%0d leftover expected=0", tag, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            applyStimulus(4'b0000, 4'b0000, 1'b0);
            checkOutput(tag);
        end
    endtask

    initial begin
        logic [12:0] asyncObs;

        i_rst_n  = 1'b0;
        reqVld   = '0;
        reqData  = '0;
        flush    = 1'b0;
        cReqVld  = '0;
        cReqData = '0;
        cFlush   = 1'b0;

        // Single request on ch2.
        resetDut();
        setIdle(0, 1, 2'd0);
        setGrant(2, 2'd2, 1'b1);
        setIdle(6, 7, 2'd2);
        enqueue(8);
        applyStimulus(4'b0100, 4'b0100, 1'b0);
        checkOutput("single");
        idleCycles(7, "single");
        checkDrained("single");

        // All four at once, served in round-robin order 0,1,2,3.
        resetDut();
        setIdle(0, 1, 2'd0);
        setGrant(2, 2'd0, 1'b1);
        setGrant(6, 2'd1, 1'b0);
        setGrant(10, 2'd2, 1'b1);
        setGrant(14, 2'd3, 1'b0);
        setIdle(18, 19, 2'd3);
        enqueue(20);
        applyStimulus(4'b1111, 4'b0101, 1'b0);
        checkOutput("allfour");
        idleCycles(19, "allfour");
        checkDrained("allfour");

        // Overwrite of a pending ch1 request.
        resetDut();
        setIdle(0, 1, 2'd0);
        setGrant(2, 2'd0, 1'b0);
        frame[4][4:1] = 4'b0010;
        setGrant(6, 2'd1, 1'b1);
        setIdle(10, 11, 2'd1);
        enqueue(12);
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        checkOutput("overwrite");
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        checkOutput("overwrite");
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("overwrite");
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        checkOutput("overwrite");
        idleCycles(8, "overwrite");
        checkDrained("overwrite");

        // Flush mid-grant, with a discarded ch0 request in the flush cycle.
        resetDut();
        setIdle(0, 1, 2'd0);
        setGrant(2, 2'd3, 1'b1);
        setIdle(4, 6, 2'd3);
        setGrant(7, 2'd1, 1'b1);
        setIdle(11, 12, 2'd1);
        enqueue(13);
        applyStimulus(4'b1000, 4'b1000, 1'b0);
        checkOutput("flush");
        idleCycles(2, "flush");
        applyStimulus(4'b0001, 4'b0000, 1'b1);
        checkOutput("flush");
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("flush");
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        checkOutput("flush");
        idleCycles(7, "flush");
        checkDrained("flush");

        // Asynchronous reset in the middle of a ch2 grant.
        resetDut();
        setIdle(0, 1, 2'd0);
        frame[2] = {1'b1, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b1};
        enqueue(3);
        applyStimulus(4'b0100, 4'b0100, 1'b0);
        checkOutput("rstmid");
        idleCycles(2, "rstmid");
        checkDrained("rstmid");
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        asyncObs = {vld, vldData, gntId, done, drop, busy};
        checks++;
        assert (asyncObs === 13'h0) else begin
            errors++;
            $error("FAIL rstmid_async observed=%h expected=%h", asyncObs, 13'h0);
        end
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cyc     = -1;

        // After reset rr pointer is back at 3, so ch1 beats ch3.
        setIdle(0, 1, 2'd0);
        setGrant(2, 2'd1, 1'b1);
        setGrant(6, 2'd3, 1'b0);
        setIdle(10, 11, 2'd3);
        enqueue(12);
        applyStimulus(4'b1010, 4'b0010, 1'b0);
        checkOutput("rstafter");
        idleCycles(11, "rstafter");
        checkDrained("rstafter");

        // Single-requester, no-gap corner: back-to-back grants.
        resetDut();
        setIdle(0, 5, 2'd0);
        enqueue(6);
        cornerQ.push_back(6'b000000);
        cornerQ.push_back(6'b000000);
        cornerQ.push_back(6'b110101);
        cornerQ.push_back(6'b100101);
        cornerQ.push_back(6'b000000);
        cornerQ.push_back(6'b000000);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        checkOutput("corner");
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("corner");
        idleCycles(4, "corner");
        checkDrained("corner");
        checks++;
        assert (cornerQ.size() == 0) else begin
            errors++;
            $error("FAIL corner_drained observed=%0d leftover expected=0", cornerQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_extend_arb.md
Name: pulse_extend_arb

Overview:
- Shares one extended-pulse output channel between REQ_NUM requesters.
- Each requester issues single-cycle valid/data pulses. The block latches each pulse as pending and picks one requester at a time, round-robin.
- The granted request drives o_vld/o_vld_data for exactly EXTEND_CYC_NUM cycles, followed by GAP_CYC_NUM idle guard cycles.
- Sits between protection/status sources and a single shared downstream stretched-pulse line. Replaces one pulse stretcher per source.

Parameters:
- REQ_NUM, 4: number of requesters; legal range 1..16.
- EXTEND_CYC_NUM, 12: o_vld high-time per grant, in cycles; must be >= 1.
- GAP_CYC_NUM, 2: forced o_vld-low cycles between consecutive grants; 0 is legal.
- IDW, derived: (REQ_NUM==1) ? 1 : $clog2(REQ_NUM).
- CNT_W, derived: $clog2(max(EXTEND_CYC_NUM, GAP_CYC_NUM) + 1).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_req_vld  in  REQ_NUM  per-requester request pulse
- i_req_data  in  REQ_NUM  per-requester data bit; sampled when the matching i_req_vld=1
- i_flush  in  1  synchronous abort of the current grant and of all pending requests
- o_vld  out  1  extended valid
- o_vld_data  out  1  extended data; 0 whenever o_vld=0
- o_gnt_id  out  IDW  index of the requester being served; holds its last value when idle
- o_done  out  REQ_NUM  one-hot pulse on the final o_vld cycle of that requester's grant
- o_drop  out  REQ_NUM  pulse: a pending request was overwritten before it was served
- o_busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; state=IDLE; cnt=0; pend=0; pend_data=0; rr_ptr=REQ_NUM-1, so requester 0 wins first.
- All outputs are registered, decoded from registered state/cnt/id.
- Pending latch, per requester k:
  - i_req_vld[k]=1 sets pend[k] and loads pend_data[k]=i_req_data[k].
  - If pend[k] is already 1 and that request is not being granted this cycle: data is overwritten, and o_drop[k]=1 on the next cycle.
  - A new pulse in the same cycle as k's grant: the set wins. The grant takes the old data and pend[k] stays 1 with the new data. No drop.
- Arbitration happens when state=IDLE, or on the final cycle of GAP (or of EXTEND when GAP_CYC_NUM=0), and any pend=1:
  - Winner = first pend index searching upward from rr_ptr+1, wrapping modulo REQ_NUM.
  - On the grant edge: rr_ptr<=winner, o_gnt_id<=winner, pend[winner] cleared, data captured, state<=EXTEND, cnt<=0.
- EXTEND state:
  - o_vld=1, o_vld_data=captured data.
  - cnt increments each cycle.
  - On cnt==EXTEND_CYC_NUM-1: o_done[id]=1 in that same cycle.
  - Next state: GAP if GAP_CYC_NUM>0. Otherwise re-arbitrate: back-to-back EXTEND if any pend, else IDLE.
- GAP state: o_vld=0 for GAP_CYC_NUM cycles, then arbitrate or go to IDLE.
- Latency from IDLE: pulse at cycle t, pend set at t+1, o_vld first high at t+2.
- A requester may re-request during its own EXTEND. The request is queued normally and served after the others per round-robin.
- i_flush=1:
  - Next cycle: state=IDLE, pend=0, o_vld=0, o_vld_data=0.
  - No o_done for the aborted grant; rr_ptr is unchanged.
  - i_req_vld in the same cycle as i_flush is discarded.
- Asynchronous reset mid-grant: everything returns to reset values immediately; no o_done is issued.
- Counter wrap: cnt never exceeds max(EXTEND_CYC_NUM, GAP_CYC_NUM)-1 and resets to 0 on every state entry.

Test Plan (REQ_NUM=4, EXTEND_CYC_NUM=3, GAP_CYC_NUM=1 unless stated):
- Single request: i_req_vld[2]=1, data=1 at cycle 0 -> o_vld=o_vld_data=1 and o_gnt_id=2 in cycles 2-4; o_done=4'b0100 at cycle 4; o_busy high cycles 2-5; IDLE at cycle 6.
- All four request at cycle 0 (data 1,0,1,0) -> o_vld windows 2-4, 6-8, 10-12, 14-16 with o_gnt_id 0,1,2,3 and o_vld_data 1,0,1,0.
- Overwrite: ch0 request at cycle 0; ch1 requests at cycles 1 (data 0) and 3 (data 1) -> o_drop[1]=1 at cycle 4; ch1 served in cycles 6-8 with o_vld_data=1.
- Flush: ch3 request at cycle 0, i_flush at cycle 3 -> o_vld high in cycles 2-3 only, low from cycle 4; no o_done; o_busy=0 at cycle 4; a ch1 request at cycle 5 is granted with o_vld at cycle 7.
- Reset mid-grant: drop i_rst_n during cycle 3 of the single-request case -> all outputs 0 asynchronously; after release, a ch1 request is served first, since rr_ptr was reset.
- Corner EXTEND_CYC_NUM=1, GAP_CYC_NUM=0, REQ_NUM=1: pulses at cycles 0 and 1 -> o_vld high in cycles 2 and 3 back-to-back, with o_done[0] in both cycles.
